// File: rtl/veritune_seq_ctrl_pkg.sv
// Shared types and defaults for the Veritune record/shift/play sequencer.
// One-hot state encoding maps directly onto the Ld7..Ld3 state LEDs.
package veritune_seq_ctrl_pkg;

  typedef enum logic [4:0] {
    S_I     = 5'b00001,
    S_REC   = 5'b00010,
    S_STOP  = 5'b00100,
    S_SHIFT = 5'b01000,
    S_PLAY  = 5'b10000
  } state_t;

  localparam int unsigned ADDR_W_DEF      = 14;
  localparam int unsigned SHIFT_TMO_W_DEF = 26;

endpackage

// File: rtl/veritune_seq_ctrl_if.sv
// Sample-RAM strobes and pitch-shifter handshake between the sequencer (master)
// and the RAM/shifter side (slave).
interface veritune_seq_ctrl_if
  import veritune_seq_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

  logic              shift_start;
  logic              shift_done;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;

  modport master (
    output shift_start, mem_we, mem_re, mem_addr,
    input  shift_done
  );

  modport slave (
    input  shift_start, mem_we, mem_re, mem_addr,
    output shift_done
  );

endinterface

// File: rtl/veritune_seq_ctrl_addr_ctr.sv
// Clearable ADDR_W sample counter with terminal-count flag; shared by the
// REC and PLAY address sequences.
module veritune_seq_ctrl_addr_ctr #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              board_clk,
  input  logic              Reset,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] count,
  output logic              tc
);

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset)    count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + ADDR_W'(1);
  end

  assign tc = (count == '1);

endmodule

// File: rtl/veritune_seq_ctrl.sv
// Veritune sequencer: Btn0 pulses walk Rec->Stop->Shift->Play->Idle.
// Define VERITUNE_LOOP_PLAY_EN to loop playback until the next button pulse.
module veritune_seq_ctrl
  import veritune_seq_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned SHIFT_TMO_W = SHIFT_TMO_W_DEF
) (
  input  logic                board_clk,
  input  logic                Reset,
  input  logic                btn_pulse,
  input  logic                sample_tick,
  veritune_seq_ctrl_if.master bus,
  output logic [ADDR_W:0]     rec_len,
  output logic                shift_err,
  output logic                q_I,
  output logic                q_Rec,
  output logic                q_Stop,
  output logic                q_Shift,
  output logic                q_Play
);

  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

  state_t                 state;
  logic [SHIFT_TMO_W-1:0] tmo;
  logic [ADDR_W-1:0]      count;
  logic                   tc;
  logic                   ctr_clr;
  logic                   ctr_inc;
  logic                   done_ok;
  logic                   last_rd;
  logic [ADDR_W:0]        rec_cnt;

  veritune_seq_ctrl_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
    .board_clk (board_clk),
    .Reset     (Reset),
    .clr       (ctr_clr),
    .inc       (ctr_inc),
    .count     (count),
    .tc        (tc)
  );

  // count is the next address to strobe; the registered mem_addr shows the
  // address of the strobe going out, so a full RAM never wraps mem_addr.
  always_comb begin
    done_ok = (state == S_SHIFT) && !bus.shift_start && bus.shift_done;
    last_rd = ({1'b0, count} == (rec_len - LEN_ONE));
    rec_cnt = {1'b0, count} + {{ADDR_W{1'b0}}, sample_tick};
    ctr_inc = sample_tick &&
              ((state == S_REC) || ((state == S_PLAY) && !btn_pulse));
    ctr_clr = ((state == S_I) && btn_pulse) || done_ok;
`ifdef VERITUNE_LOOP_PLAY_EN
    if ((state == S_PLAY) && !btn_pulse && sample_tick && last_rd) ctr_clr = 1'b1;
`endif
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state           <= S_I;
      tmo             <= '0;
      rec_len         <= '0;
      shift_err       <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_re      <= 1'b0;
      bus.shift_start <= 1'b0;
      bus.mem_addr    <= '0;
    end else begin
      bus.mem_we      <= 1'b0;
      bus.mem_re      <= 1'b0;
      bus.shift_start <= 1'b0;
      case (state)
        S_I: if (btn_pulse) begin
          state        <= S_REC;
          bus.mem_addr <= '0;
          shift_err    <= 1'b0;
        end
        S_REC: begin
          if (sample_tick) begin
            bus.mem_we   <= 1'b1;
            bus.mem_addr <= count;
          end
          if (btn_pulse || (sample_tick && tc)) begin
            rec_len <= rec_cnt;
            state   <= (rec_cnt == '0) ? S_I : S_STOP;
          end
        end
        S_STOP: if (btn_pulse) begin
          state           <= S_SHIFT;
          bus.shift_start <= 1'b1;
          tmo             <= SHIFT_TMO_W'(1);
        end
        S_SHIFT: begin
          tmo <= tmo + SHIFT_TMO_W'(1);
          if (done_ok) begin
            state        <= S_PLAY;
            bus.mem_addr <= '0;
          end else if (tmo == '1) begin
            state     <= S_STOP;
            shift_err <= 1'b1;
          end
        end
        S_PLAY: begin
          if (btn_pulse) begin
            state <= S_I;
          end else if (sample_tick) begin
            bus.mem_re   <= 1'b1;
            bus.mem_addr <= count;
`ifndef VERITUNE_LOOP_PLAY_EN
            if (last_rd) state <= S_I;
`endif
          end
        end
        default: state <= S_I;
      endcase
    end
  end

  assign q_I     = state[0];
  assign q_Rec   = state[1];
  assign q_Stop  = state[2];
  assign q_Shift = state[3];
  assign q_Play  = state[4];

endmodule
